// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the control FSM that talks to it.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'b00,
    MEM_WAIT    = 2'b01,
    MEM_RESPOND = 2'b10
  } mem_state_e;

  localparam logic [31:0] NOP_INSTRUCTION = 32'hE1A00000;
  localparam int          WAIT_CNT_W      = 4;

  // True when the byte address points past the end of a 2**aw word array.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_ram_array.sv
// Single-port synchronous RAM with write-first registered read data.
// Byte lane enables exist only when MEM_BYTE_WRITE_EN is defined.
module mem_ram_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [3:0]            byte_en,
`endif
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] new_word;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            lane_en;

  always_comb begin
    lane_en = 4'hF;
`ifdef MEM_BYTE_WRITE_EN
    lane_en = byte_en;
`endif
    old_word = mem[addr];
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) new_word[8*i +: 8] = wdata[8*i +: 8];
    end
    rdata_d = rdata_q;
    if (en) rdata_d = we ? new_word : old_word;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (en && we && lane_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // The read register is the responder's data output, so it resets to a NOP.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= NOP_INSTRUCTION;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request in flight, WAIT_STATES extra cycles, ready pulse.
// Optional MEM_BYTE_WRITE_EN adds per-byte write lanes via in_byte_en.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in_address,
  input  logic                  in_req,
  input  logic                  in_write_en,
  input  logic                  in_data_out_en,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [3:0]            in_byte_en,
`endif
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ready,
  output logic                  out_busy,
  output logic                  out_fault
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
    WAIT_CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  mem_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  doe_q, doe_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  fault_q, fault_d;
`ifdef MEM_BYTE_WRITE_EN
  logic [3:0]            be_q, be_d;
`endif

  logic                  idle;
  logic [31:0]           req_addr;
  logic                  req_write;
  logic                  req_doe;
  logic [DATA_WIDTH-1:0] req_data;
  logic [3:0]            req_be;
  logic                  req_fault;
  logic                  go_respond;
  logic                  ram_en;

  // With zero wait states the RAM access happens on the capture edge itself,
  // so the request view bypasses the capture registers while idle.
  always_comb begin
    idle      = (state_q == MEM_IDLE);
    req_addr  = idle ? in_address     : addr_q;
    req_write = idle ? in_write_en    : write_q;
    req_doe   = idle ? in_data_out_en : doe_q;
    req_data  = idle ? in_data        : data_q;
    req_be    = 4'hF;
`ifdef MEM_BYTE_WRITE_EN
    req_be    = idle ? in_byte_en     : be_q;
`endif
    req_fault = (req_addr[1:0] != 2'b00)
             || addr_out_of_range(req_addr, ADDR_WIDTH)
             || (req_write && !req_doe)
             || (req_write && (req_be == 4'h0));
    go_respond = (idle && in_req && (WAIT_STATES == 0))
              || ((state_q == MEM_WAIT) && (wait_cnt_q == LAST_WAIT));
    ram_en = go_respond && !req_fault && !reset;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    doe_d      = doe_q;
    data_d     = data_q;
`ifdef MEM_BYTE_WRITE_EN
    be_d       = be_q;
`endif
    case (state_q)
      MEM_IDLE: begin
        if (in_req) begin
          addr_d  = in_address;
          write_d = in_write_en;
          doe_d   = in_data_out_en;
          data_d  = in_data;
`ifdef MEM_BYTE_WRITE_EN
          be_d    = in_byte_en;
`endif
          if (WAIT_STATES == 0) begin
            state_d = MEM_RESPOND;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = '0;
          end
        end
      end
      MEM_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) state_d = MEM_RESPOND;
        else                         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      MEM_RESPOND: state_d = MEM_IDLE;
      default:     state_d = MEM_IDLE;
    endcase
    ready_d = (state_d == MEM_RESPOND);
    busy_d  = (state_d != MEM_IDLE);
    fault_d = go_respond && req_fault;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    write_q <= write_d;
    doe_q   <= doe_d;
    data_q  <= data_d;
`ifdef MEM_BYTE_WRITE_EN
    be_q    <= be_d;
`endif
  end

  mem_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .en      (ram_en),
    .we      (req_write),
    .addr    (req_addr[ADDR_WIDTH+1:2]),
    .wdata   (req_data),
`ifdef MEM_BYTE_WRITE_EN
    .byte_en (req_be),
`endif
    .rdata   (out_data)
  );

  assign out_ready = ready_q;
  assign out_busy  = busy_q;
  assign out_fault = fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with no wait states and one with three, scoreboard-checked.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_address     [2];
  logic        in_req         [2];
  logic        in_write_en    [2];
  logic        in_data_out_en [2];
  logic [31:0] in_data        [2];
  logic [3:0]  in_byte_en     [2];
  logic [31:0] out_data       [2];
  logic        out_ready      [2];
  logic        out_busy       [2];
  logic        out_fault      [2];

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .DATA_WIDTH(32)) u_ws0 (
    .clk            (clk),
    .reset          (reset),
    .in_address     (in_address[0]),
    .in_req         (in_req[0]),
    .in_write_en    (in_write_en[0]),
    .in_data_out_en (in_data_out_en[0]),
    .in_data        (in_data[0]),
`ifdef MEM_BYTE_WRITE_EN
    .in_byte_en     (in_byte_en[0]),
`endif
    .out_data       (out_data[0]),
    .out_ready      (out_ready[0]),
    .out_busy       (out_busy[0]),
    .out_fault      (out_fault[0])
  );

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3), .DATA_WIDTH(32)) u_ws3 (
    .clk            (clk),
    .reset          (reset),
    .in_address     (in_address[1]),
    .in_req         (in_req[1]),
    .in_write_en    (in_write_en[1]),
    .in_data_out_en (in_data_out_en[1]),
    .in_data        (in_data[1]),
`ifdef MEM_BYTE_WRITE_EN
    .in_byte_en     (in_byte_en[1]),
`endif
    .out_data       (out_data[1]),
    .out_ready      (out_ready[1]),
    .out_busy       (out_busy[1]),
    .out_fault      (out_fault[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic [31:0] addr, input logic we, input logic doe,
                       input logic [31:0] data, input logic [3:0] be);
    in_address[d]     = addr;
    in_write_en[d]    = we;
    in_data_out_en[d] = doe;
    in_data[d]        = data;
    in_byte_en[d]     = be;
    in_req[d]         = 1'b1;
  endtask

  // One request: push the expectation, issue it, wait (bounded) for out_ready, compare.
  task automatic txn(input string tag, input int d, input logic [31:0] addr, input logic we,
                     input logic doe, input logic [31:0] data, input logic [3:0] be,
                     input logic [31:0] exp_data, input logic exp_fault);
    exp_t e;
    exp_t got;
    int   lat;
    e.d = d; e.data = exp_data; e.fault = exp_fault;
    sb.push_back(e);
    @(negedge clk);
    drive(d, addr, we, doe, data, be);
    @(negedge clk);
    in_req[d] = 1'b0;
    lat = 1;
    while (out_ready[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = sb.pop_front();
    check({tag, "_ready"}, {31'd0, out_ready[d]}, 32'd1);
    check({tag, "_lat"},   32'(lat), (got.d == 0) ? 32'd1 : 32'd4);
    check({tag, "_data"},  out_data[d], got.data);
    check({tag, "_fault"}, {31'd0, out_fault[d]}, {31'd0, got.fault});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t got;
    int   busy_n;
    int   rdy_n;
    int   rdy_at;

    for (int d = 0; d < 2; d++) begin
      in_address[d] = '0; in_req[d] = 1'b0; in_write_en[d] = 1'b0;
      in_data_out_en[d] = 1'b0; in_data[d] = '0; in_byte_en[d] = 4'hF;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      check("rst_data",  out_data[d], 32'hE1A00000);
      check("rst_ready", {31'd0, out_ready[d]}, 32'd0);
      check("rst_busy",  {31'd0, out_busy[d]},  32'd0);
      check("rst_fault", {31'd0, out_fault[d]}, 32'd0);
    end

    txn("ws0_wr", 0, 32'h10, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
    txn("ws0_rd", 0, 32'h10, 1'b0, 1'b1, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);

    txn("ws3_wr", 1, 32'h4, 1'b1, 1'b1, 32'h12345678, 4'hF, 32'h12345678, 1'b0);

    // Read with a stray request in the middle of the wait window.
    got.d = 1; got.data = 32'h12345678; got.fault = 1'b0;
    sb.push_back(got);
    @(negedge clk);
    drive(1, 32'h4, 1'b0, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    in_req[1] = 1'b0;
    busy_n = 0; rdy_n = 0; rdy_at = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) drive(1, 32'h10, 1'b1, 1'b1, 32'h55555555, 4'hF);
      if (c == 3) in_req[1] = 1'b0;
      if (out_busy[1] === 1'b1) busy_n++;
      if (out_ready[1] === 1'b1) begin
        rdy_n++;
        rdy_at = c;
        if (sb.size() > 0) begin
          got = sb.pop_front();
          check("ws3_rd_data",  out_data[1], got.data);
          check("ws3_rd_fault", {31'd0, out_fault[1]}, {31'd0, got.fault});
        end
      end
      @(negedge clk);
    end
    while (sb.size() > 0) void'(sb.pop_front());
    check("ws3_busy_cycles", 32'(busy_n), 32'd4);
    check("ws3_ready_count", 32'(rdy_n),  32'd1);
    check("ws3_ready_cycle", 32'(rdy_at), 32'd4);

    txn("flt_unal",  1, 32'h6,    1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h12345678, 1'b1);
    txn("flt_range", 1, 32'h1000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h12345678, 1'b1);
    txn("rb1",       1, 32'h4,    1'b0, 1'b0, 32'h0,        4'hF, 32'h12345678, 1'b0);
    txn("flt_noe",   1, 32'h4,    1'b1, 1'b0, 32'hCAFEF00D, 4'hF, 32'h12345678, 1'b1);
    txn("rb2",       1, 32'h4,    1'b0, 1'b0, 32'h0,        4'hF, 32'h12345678, 1'b0);

    // Reset lands while the write sits in WAIT.
    @(negedge clk);
    drive(1, 32'h4, 1'b1, 1'b1, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    in_req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_busy", {31'd0, out_busy[1]}, 32'd0);
    check("rstw_data", out_data[1], 32'hE1A00000);
    rdy_n = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_ready[1] === 1'b1) rdy_n++;
      @(negedge clk);
    end
    check("rstw_no_ready", 32'(rdy_n), 32'd0);
    txn("rb3", 1, 32'h4, 1'b0, 1'b0, 32'h0, 4'hF, 32'h12345678, 1'b0);

`ifdef MEM_BYTE_WRITE_EN
    txn("be_full", 1, 32'h8, 1'b1, 1'b1, 32'h11223344, 4'hF,    32'h11223344, 1'b0);
    txn("be_0101", 1, 32'h8, 1'b1, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 1'b0);
    txn("be_rd",   1, 32'h8, 1'b0, 1'b0, 32'h0,        4'hF,    32'h11BB33DD, 1'b0);
    txn("be_zero", 1, 32'h8, 1'b1, 1'b1, 32'hFFFFFFFF, 4'h0,    32'h11BB33DD, 1'b1);
    txn("be_rd2",  1, 32'h8, 1'b0, 1'b0, 32'h0,        4'hF,    32'h11BB33DD, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("end_busy0",  {31'd0, out_busy[0]},  32'd0);
    check("end_fault1", {31'd0, out_fault[1]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
